// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready request/response handshake. Logic ops and ADD/SUB take one
// cycle. An optional unsigned multiply is performed by iterative shift-add.
module alu_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;
    localparam logic [3:0] OpNor = 4'b1100;
    localparam logic [3:0] OpMul = 4'b1000;

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic               is_sub;
    logic               is_mul;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_ext;
    logic               add_ovf;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               alu_ill;
    logic [2*WIDTH-1:0] prod_step;

    // Shared adder: SUB and SLT both compute a + ~b + 1.
    always_comb begin
        is_sub  = (ctrl == OpSub) || (ctrl == OpSlt);
        is_mul  = (MUL_EN != 0) && (ctrl == OpMul);
        b_eff   = is_sub ? ~b : b;
        sum_ext = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 1)'(is_sub);
        add_ovf = (a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_ext[WIDTH-1]) ^ sum_ext[WIDTH];

        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        case (ctrl)
            OpAnd: alu_res = a & b;
            OpOr:  alu_res = a | b;
            OpNor: alu_res = ~(a | b);
            OpAdd, OpSub: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = add_ovf;
            end
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ add_ovf};
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        ill_d     = ill_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (is_mul) begin
                        prod_d   = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        cnt_d    = '0;
                        state_d  = StBusy;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        carry_d  = alu_carry;
                        ovf_d    = alu_ovf;
                        ill_d    = alu_ill;
                        state_d  = StDone;
                    end
                end
            end
            StBusy: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastStep) begin
                    result_d = prod_step[WIDTH-1:0];
                    zero_d   = (prod_step[WIDTH-1:0] == '0);
                    carry_d  = 1'b0;
                    ovf_d    = |prod_step[2*WIDTH-1:WIDTH];
                    ill_d    = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

endmodule
